// File: rtl/spi_adc_amp_responder_pkg.sv
// Shared types and frame geometry for the SPI front-end responder (LTC6912 amp + LTC1407A ADC).
package front_end_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    AMP_SHIFT = 2'd1,
    ADC_SHIFT = 2'd2
  } state_e;

  localparam int FRAME_LEN = 34;
  localparam int CHA_MSB   = 2;
  localparam int CHB_MSB   = 18;
  localparam int AMP_BITS  = 8;

endpackage

// File: rtl/spi_adc_amp_responder_edge_sync.sv
// Multi-flop synchronizer plus edge detector for one asynchronous SPI pin.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      // Registered pulses line up with level (prev_q) on the same clock.
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/spi_adc_amp_responder.sv
// SPI responder emulating an LTC6912 gain DAC and an LTC1407A dual ADC on one bus.
// Optional macro AMP_READBACK_EN: previous gain byte is returned on miso during an amp write.
module spi_adc_amp_responder #(
  parameter int DATA_W      = 14,
  parameter int FRAME_LEN   = front_end_pkg::FRAME_LEN,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spi_clk,
  input  logic                     mosi,
  input  logic                     cs_amp,
  input  logic                     adc_conv,
  input  logic signed [DATA_W-1:0] sample_a,
  input  logic signed [DATA_W-1:0] sample_b,
  output logic                     miso,
  output logic [3:0]               gain_a,
  output logic [3:0]               gain_b,
  output logic                     gain_valid,
  output logic                     frame_done,
  output logic                     busy
);

  import front_end_pkg::*;

  logic spi_lvl, spi_rise, spi_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic conv_lvl, conv_rise, conv_fall;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_spi (
    .clk(clk), .rst(rst), .din(spi_clk),
    .level(spi_lvl), .rise(spi_rise), .fall(spi_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din(cs_amp),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_conv (
    .clk(clk), .rst(rst), .din(adc_conv),
    .level(conv_lvl), .rise(conv_rise), .fall(conv_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{spi_lvl, cs_lvl, conv_lvl, conv_fall, mosi_rise, mosi_fall};

  // Whole ADC frame is built at conversion time and shifted out MSB first.
  function automatic logic [FRAME_LEN-1:0] build_frame(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [FRAME_LEN-1:0] f;
    f = '0;
    f[FRAME_LEN-1-CHA_MSB -: DATA_W] = a;
    f[FRAME_LEN-1-CHB_MSB -: DATA_W] = b;
    return f;
  endfunction

  state_e               state;
  logic [5:0]           bit_cnt;
  logic [7:0]           amp_sr;
  logic [FRAME_LEN-1:0] frame_sr;
`ifdef AMP_READBACK_EN
  logic [7:0]           rb_sr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      amp_sr     <= '0;
      frame_sr   <= '0;
      miso       <= 1'b0;
      gain_a     <= '0;
      gain_b     <= '0;
      gain_valid <= 1'b0;
      frame_done <= 1'b0;
`ifdef AMP_READBACK_EN
      rb_sr      <= '0;
`endif
    end else begin
      gain_valid <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          miso <= 1'b0;
          // Amplifier select takes priority over a coincident conversion strobe.
          if (cs_fall) begin
            state   <= AMP_SHIFT;
            bit_cnt <= '0;
            amp_sr  <= '0;
`ifdef AMP_READBACK_EN
            rb_sr   <= {gain_b, gain_a};
            miso    <= gain_b[3];
`endif
          end else if (conv_rise) begin
            state    <= ADC_SHIFT;
            bit_cnt  <= '0;
            frame_sr <= build_frame(sample_a, sample_b);
          end
        end

        AMP_SHIFT: begin
          if (cs_rise) begin
            state <= IDLE;
            miso  <= 1'b0;
            if (bit_cnt == 6'(AMP_BITS)) begin
              gain_a     <= amp_sr[3:0];
              gain_b     <= amp_sr[7:4];
              gain_valid <= 1'b1;
            end
          end else begin
            if (spi_rise) begin
              amp_sr <= {amp_sr[6:0], mosi_lvl};
              if (bit_cnt != 6'(AMP_BITS)) bit_cnt <= bit_cnt + 6'd1;
            end
`ifdef AMP_READBACK_EN
            // Zero fill leaves miso low once all eight readback bits are out.
            if (spi_fall) begin
              rb_sr <= {rb_sr[6:0], 1'b0};
              miso  <= rb_sr[6];
            end
`else
            miso <= 1'b0;
`endif
          end
        end

        ADC_SHIFT: begin
          if (conv_rise) begin
            bit_cnt  <= '0;
            miso     <= 1'b0;
            frame_sr <= build_frame(sample_a, sample_b);
          end else if (spi_fall) begin
            if (bit_cnt == 6'(FRAME_LEN - 1)) begin
              state      <= IDLE;
              bit_cnt    <= '0;
              miso       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              bit_cnt  <= bit_cnt + 6'd1;
              miso     <= frame_sr[FRAME_LEN-1];
              frame_sr <= {frame_sr[FRAME_LEN-2:0], 1'b0};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_adc_amp_responder.sv
// Directed bench for spi_adc_amp_responder: gain writes, ADC frames, restart and async reset.
module tb_spi_adc_amp_responder;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              spi_clk = 1'b0;
  logic              mosi = 1'b0;
  logic              cs_amp = 1'b1;
  logic              adc_conv = 1'b0;
  logic signed [13:0] sample_a = '0;
  logic signed [13:0] sample_b = '0;
  logic              miso;
  logic [3:0]        gain_a;
  logic [3:0]        gain_b;
  logic              gain_valid;
  logic              frame_done;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int gv_cnt = 0;
  int fd_cnt = 0;
  int both_cnt = 0;

  spi_adc_amp_responder dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .mosi(mosi), .cs_amp(cs_amp),
    .adc_conv(adc_conv), .sample_a(sample_a), .sample_b(sample_b), .miso(miso),
    .gain_a(gain_a), .gain_b(gain_b), .gain_valid(gain_valid),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gain_valid) gv_cnt++;
    if (frame_done) fd_cnt++;
    if (gain_valid && frame_done) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic amp_write(input logic [7:0] data, input int nbits, output logic [7:0] rb);
    rb = '0;
    cs_amp = 1'b0;
    hold(6);
    check("amp_busy", 32'(busy), 32'd1);
    for (int i = 0; i < nbits; i++) begin
      mosi = data[7-i];
      hold(6);
      rb = {rb[6:0], miso};
      spi_clk = 1'b1;
      hold(6);
      spi_clk = 1'b0;
    end
    hold(6);
    cs_amp = 1'b1;
    hold(10);
  endtask

  task automatic adc_frame(input logic [13:0] a, input logic [13:0] b, input int stop_at,
                           output logic [33:0] cap);
    sample_a = a;
    sample_b = b;
    adc_conv = 1'b1;
    hold(6);
    adc_conv = 1'b0;
    hold(6);
    cap = '0;
    for (int k = 0; k < 34; k++) begin
      if (k == stop_at) return;
      spi_clk = 1'b1;
      hold(6);
      spi_clk = 1'b0;
      hold(6);
      cap = {cap[32:0], miso};
    end
  endtask

  logic [7:0]  rb;
  logic [33:0] cap;
  int          gv0, fd0;

  initial begin
    hold(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_gain_a", 32'(gain_a), 32'd0);
    check("rst_gain_b", 32'(gain_b), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pulses", 32'(gain_valid | frame_done), 32'd0);
    rst = 1'b1;
    hold(10);

    gv0 = gv_cnt;
    amp_write(8'h5A, 8, rb);
    check("gain_a_5A", 32'(gain_a), 32'hA);
    check("gain_b_5A", 32'(gain_b), 32'h5);
    check("gv_5A", 32'(gv_cnt - gv0), 32'd1);
    check("rb_first", 32'(rb), 32'h00);
    check("amp_idle", 32'(busy), 32'd0);

    gv0 = gv_cnt;
    amp_write(8'hFF, 5, rb);
    check("short_gain_a", 32'(gain_a), 32'hA);
    check("short_gain_b", 32'(gain_b), 32'h5);
    check("short_gv", 32'(gv_cnt - gv0), 32'd0);
`ifdef AMP_READBACK_EN
    check("short_rb", 32'(rb), 32'h0B);
`else
    check("short_rb", 32'(rb), 32'h00);
`endif

    fd0 = fd_cnt;
    adc_frame(14'h1ABC, 14'h2345, -1, cap);
    check("adc_pre", 32'(cap[33:32]), 32'd0);
    check("adc_cha", 32'(cap[31:18]), 32'h1ABC);
    check("adc_mid", 32'(cap[17:16]), 32'd0);
    check("adc_chb", 32'(cap[15:2]), 32'h2345);
    check("adc_post", 32'(cap[1:0]), 32'd0);
    hold(4);
    check("adc_fd", 32'(fd_cnt - fd0), 32'd1);
    check("adc_idle", 32'(busy), 32'd0);
    check("adc_miso_idle", 32'(miso), 32'd0);

    fd0 = fd_cnt;
    adc_frame(14'h1ABC, 14'h2345, 10, cap);
    check("restart_busy", 32'(busy), 32'd1);
    adc_frame(14'h0001, 14'h2345, -1, cap);
    check("restart_cha", 32'(cap[31:18]), 32'h0001);
    check("restart_chb", 32'(cap[15:2]), 32'h2345);
    check("restart_zeros", 32'({cap[33:32], cap[17:16], cap[1:0]}), 32'd0);
    hold(4);
    check("restart_fd", 32'(fd_cnt - fd0), 32'd1);

    gv0 = gv_cnt;
    amp_write(8'h11, 8, rb);
`ifdef AMP_READBACK_EN
    check("readback", 32'(rb), 32'h5A);
`else
    check("readback", 32'(rb), 32'h00);
`endif
    check("gain_a_11", 32'(gain_a), 32'h1);
    check("gain_b_11", 32'(gain_b), 32'h1);
    check("gv_11", 32'(gv_cnt - gv0), 32'd1);

    adc_frame(14'h1ABC, 14'h2345, 20, cap);
    check("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_miso", 32'(miso), 32'd0);
    check("arst_gain_a", 32'(gain_a), 32'd0);
    check("arst_gain_b", 32'(gain_b), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pulses", 32'(gain_valid | frame_done), 32'd0);
    hold(3);
    rst = 1'b1;
    hold(20);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("pulse_overlap", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
